// File: rtl/alu_operand_sequencer_if.sv
// Instruction handshake, ALU operand/result bus and writeback port of alu_operand_sequencer.
// master = upstream/ALU side, slave = the sequencer.
interface alu_operand_sequencer_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned RA_W    = 3;

   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;

   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_b;
   logic [OP_W-1:0]    alu_op;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_zero;
   logic               alu_neg;
   logic               alu_carry;
   logic               alu_overflow;

   logic               wb_valid;
   logic [RA_W-1:0]    wb_addr;
   logic [WIDTH-1:0]   wb_data;

   modport master (
      output instr_valid, instr,
      output alu_result, alu_zero, alu_neg, alu_carry, alu_overflow,
      input  instr_ready, alu_a, alu_b, alu_op,
      input  wb_valid, wb_addr, wb_data
   );

   modport slave (
      input  instr_valid, instr,
      input  alu_result, alu_zero, alu_neg, alu_carry, alu_overflow,
      output instr_ready, alu_a, alu_b, alu_op,
      output wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Four-cycle operand fetch / execute / writeback shell around the datapath_core ALU.
// Optional feature: define R0_ZERO_EN to hardwire register 0 to zero.
module alu_operand_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_operand_sequencer_if.slave bus,
   output logic [3:0]             flags,
   output logic                   busy,
   input  logic [2:0]             dbg_addr,
   output logic [WIDTH-1:0]       dbg_data
);
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned RA_W    = 3;
   localparam int unsigned FLAG_W  = 4;
   localparam int unsigned IMM_W   = 8;

`ifdef R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} state_t;

   state_t              state_q;
   state_t              state_d;
   logic                accept;
   logic [INSTR_W-1:0]  instr_q;
   logic [FLAG_W-1:0]   flags_cap;
   logic [WIDTH-1:0]    rf [NREGS];

   logic [OP_W-1:0]     op;
   logic [RA_W-1:0]     rd;
   logic [RA_W-1:0]     rs1;
   logic [RA_W-1:0]     rs2;
   logic [IMM_W-1:0]    imm;
   logic                is_alu;
   logic                is_li;
   logic                is_write;
   logic                rd_ok;

   // Field decode of the latched instruction
   always_comb begin
      op       = instr_q[15:12];
      rd       = instr_q[11:9];
      rs1      = instr_q[8:6];
      rs2      = instr_q[5:3];
      imm      = instr_q[7:0];
      is_alu   = ~op[3];
      is_li    = (op == 4'b1000);
      is_write = is_alu | is_li;
      rd_ok    = !(R0_ZERO && (rd == 3'd0));
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.instr_valid) begin
               accept  = 1'b1;
               state_d = OPRD;
            end
         end
         OPRD:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand, capture and writeback registers; instr_ready/busy track the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q         <= '0;
         flags_cap       <= '0;
         flags           <= '0;
         busy            <= 1'b0;
         bus.instr_ready <= 1'b1;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         bus.alu_op      <= '0;
         bus.wb_valid    <= 1'b0;
         bus.wb_addr     <= '0;
         bus.wb_data     <= '0;
         for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         bus.instr_ready <= (state_d == IDLE);
         busy            <= (state_d != IDLE);
         bus.wb_valid    <= 1'b0;

         if (accept) instr_q <= bus.instr;

         if (state_q == OPRD) begin
            if (is_alu) begin
               bus.alu_a  <= rf[rs1];
               bus.alu_b  <= rf[rs2];
               bus.alu_op <= op;
            end else if (is_li) begin
               bus.alu_a  <= WIDTH'(imm);
               bus.alu_b  <= '0;
               bus.alu_op <= '0;
            end else begin
               bus.alu_a  <= '0;
               bus.alu_b  <= '0;
               bus.alu_op <= '0;
            end
         end

         // wb_data doubles as the captured result register
         if (state_q == EXEC) begin
            flags_cap <= {bus.alu_zero, bus.alu_neg, bus.alu_carry, bus.alu_overflow};
            if (is_write) begin
               bus.wb_valid <= 1'b1;
               bus.wb_addr  <= rd;
               bus.wb_data  <= bus.alu_result;
            end
         end

         if (state_q == WB) begin
            if (is_write && rd_ok) rf[rd] <= bus.wb_data;
            if (is_alu)            flags  <= flags_cap;
         end
      end
   end

   // Register 0 is never written when hardwired, so a plain read returns 0
   assign dbg_data = rf[dbg_addr];

endmodule
